// File: rtl/mdp3_order_book.sv
// Price-sorted, depth-limited bid/ask order book for one security, fed by MDP3_Parser entries.
// Optional BOOK_STATS_EN adds saturating applied/filtered/miss counters.
module mdp3_order_book #(
    parameter int          DEPTH  = 10,
    parameter logic [31:0] SEC_ID = 32'd0,
    parameter int          LVL_W  = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             message_ready,
    input  logic [7:0]       NUM_ORDERS,
    input  logic [15:0]      QUANTITY,
    input  logic [63:0]      PRICE,
    input  logic [1:0]       ACTION,
    input  logic [1:0]       ENTRY_TYPE,
    input  logic [31:0]      SECURITY_ID,
    output logic             enable_order_book,
    output logic [63:0]      best_bid_price,
    output logic [15:0]      best_bid_qty,
    output logic [63:0]      best_ask_price,
    output logic [15:0]      best_ask_qty,
    output logic [LVL_W-1:0] bid_count,
    output logic [LVL_W-1:0] ask_count,
    output logic             book_update,
    output logic             miss_err
`ifdef BOOK_STATS_EN
    ,
    output logic [31:0]      stat_applied,
    output logic [31:0]      stat_filtered,
    output logic [31:0]      stat_miss
`endif
);

    typedef enum logic [1:0] {IDLE, SCAN, APPLY} state_t;

    state_t            state_q, state_d;
    logic [63:0]       price_q [2][DEPTH];
    logic [63:0]       price_d [2][DEPTH];
    logic [15:0]       qty_q   [2][DEPTH];
    logic [15:0]       qty_d   [2][DEPTH];
    logic [7:0]        num_q   [2][DEPTH];
    logic [7:0]        num_d   [2][DEPTH];
    logic [LVL_W-1:0]  cnt_q   [2];
    logic [LVL_W-1:0]  cnt_d   [2];
    logic [LVL_W-1:0]  idx_q, idx_d;
    logic              hit_q, hit_d;
    logic              side_q, side_d;
    logic [1:0]        act_q, act_d;
    logic [63:0]       e_price_q, e_price_d;
    logic [15:0]       e_qty_q, e_qty_d;
    logic [7:0]        e_num_q, e_num_d;
    logic              book_update_q, book_update_d;
    logic              miss_err_q, miss_err_d;

    logic              keep;
    logic [LVL_W-1:0]  cur_cnt;
    logic [63:0]       lvl_price;
    logic              in_range, eq, better, stop;

    assign keep = (SECURITY_ID == SEC_ID) && !ENTRY_TYPE[1];

    always_comb begin
        cur_cnt   = cnt_q[side_q];
        lvl_price = '0;
        for (int k = 0; k < DEPTH; k++)
            if (idx_q == LVL_W'(k)) lvl_price = price_q[side_q][k];
        in_range = idx_q < cur_cnt;
        eq       = in_range && (e_price_q == lvl_price);
        // Bid side improves upward, ask side improves downward.
        better   = side_q ? ($signed(e_price_q) < $signed(lvl_price))
                          : ($signed(e_price_q) > $signed(lvl_price));
        stop     = !in_range || eq || (act_q == 2'd0 && better);
    end

    always_comb begin
        state_d       = state_q;
        price_d       = price_q;
        qty_d         = qty_q;
        num_d         = num_q;
        cnt_d         = cnt_q;
        idx_d         = idx_q;
        hit_d         = hit_q;
        side_d        = side_q;
        act_d         = act_q;
        e_price_d     = e_price_q;
        e_qty_d       = e_qty_q;
        e_num_d       = e_num_q;
        book_update_d = 1'b0;
        miss_err_d    = 1'b0;
        case (state_q)
            IDLE: begin
                if (message_ready && keep) begin
                    side_d    = ENTRY_TYPE[0];
                    act_d     = ACTION;
                    e_price_d = PRICE;
                    e_qty_d   = QUANTITY;
                    e_num_d   = NUM_ORDERS;
                    idx_d     = '0;
                    hit_d     = 1'b0;
                    state_d   = (ACTION == 2'd3) ? APPLY : SCAN;
                end
            end
            SCAN: begin
                if (stop) begin
                    hit_d   = eq;
                    state_d = APPLY;
                end else begin
                    idx_d = idx_q + LVL_W'(1);
                end
            end
            APPLY: begin
                state_d = IDLE;
                if (act_q == 2'd3) begin
                    for (int k = 0; k < DEPTH; k++) begin
                        price_d[side_q][k] = '0;
                        qty_d[side_q][k]   = '0;
                        num_d[side_q][k]   = '0;
                    end
                    cnt_d[side_q] = '0;
                    book_update_d = 1'b1;
                end else if (hit_q && act_q != 2'd2) begin
                    // Equal-price new behaves like change.
                    for (int k = 0; k < DEPTH; k++)
                        if (idx_q == LVL_W'(k)) begin
                            qty_d[side_q][k] = e_qty_q;
                            num_d[side_q][k] = e_num_q;
                        end
                    book_update_d = 1'b1;
                end else if (act_q == 2'd0) begin
                    if (idx_q != LVL_W'(DEPTH)) begin
                        for (int k = 1; k < DEPTH; k++)
                            if (LVL_W'(k) > idx_q) begin
                                price_d[side_q][k] = price_q[side_q][k-1];
                                qty_d[side_q][k]   = qty_q[side_q][k-1];
                                num_d[side_q][k]   = num_q[side_q][k-1];
                            end
                        for (int k = 0; k < DEPTH; k++)
                            if (idx_q == LVL_W'(k)) begin
                                price_d[side_q][k] = e_price_q;
                                qty_d[side_q][k]   = e_qty_q;
                                num_d[side_q][k]   = e_num_q;
                            end
                        if (cur_cnt != LVL_W'(DEPTH)) cnt_d[side_q] = cur_cnt + LVL_W'(1);
                        book_update_d = 1'b1;
                    end
                end else if (hit_q) begin
                    // Delete: close the gap, then clear the vacated tail slot.
                    for (int k = 0; k < DEPTH - 1; k++)
                        if (LVL_W'(k) >= idx_q) begin
                            price_d[side_q][k] = price_q[side_q][k+1];
                            qty_d[side_q][k]   = qty_q[side_q][k+1];
                            num_d[side_q][k]   = num_q[side_q][k+1];
                        end
                    for (int k = 0; k < DEPTH; k++)
                        if (LVL_W'(k) == cur_cnt - LVL_W'(1)) begin
                            price_d[side_q][k] = '0;
                            qty_d[side_q][k]   = '0;
                            num_d[side_q][k]   = '0;
                        end
                    cnt_d[side_q] = cur_cnt - LVL_W'(1);
                    book_update_d = 1'b1;
                end else begin
                    miss_err_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= IDLE;
            price_q       <= '{default: '0};
            qty_q         <= '{default: '0};
            num_q         <= '{default: '0};
            cnt_q         <= '{default: '0};
            idx_q         <= '0;
            hit_q         <= 1'b0;
            side_q        <= 1'b0;
            act_q         <= 2'd0;
            e_price_q     <= '0;
            e_qty_q       <= '0;
            e_num_q       <= '0;
            book_update_q <= 1'b0;
            miss_err_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            price_q       <= price_d;
            qty_q         <= qty_d;
            num_q         <= num_d;
            cnt_q         <= cnt_d;
            idx_q         <= idx_d;
            hit_q         <= hit_d;
            side_q        <= side_d;
            act_q         <= act_d;
            e_price_q     <= e_price_d;
            e_qty_q       <= e_qty_d;
            e_num_q       <= e_num_d;
            book_update_q <= book_update_d;
            miss_err_q    <= miss_err_d;
        end
    end

    assign enable_order_book = (state_q == IDLE);
    assign best_bid_price    = price_q[0][0];
    assign best_bid_qty      = qty_q[0][0];
    assign best_ask_price    = price_q[1][0];
    assign best_ask_qty      = qty_q[1][0];
    assign bid_count         = cnt_q[0];
    assign ask_count         = cnt_q[1];
    assign book_update       = book_update_q;
    assign miss_err          = miss_err_q;

`ifdef BOOK_STATS_EN
    logic [31:0] stat_applied_q, stat_applied_d;
    logic [31:0] stat_filtered_q, stat_filtered_d;
    logic [31:0] stat_miss_q, stat_miss_d;
    logic        filt_inc;

    always_comb begin
        filt_inc = (state_q == IDLE && message_ready && !keep) ||
                   (state_q == APPLY && act_q == 2'd0 && !hit_q && idx_q == LVL_W'(DEPTH));
        stat_applied_d  = stat_applied_q;
        stat_filtered_d = stat_filtered_q;
        stat_miss_d     = stat_miss_q;
        if (book_update_d && stat_applied_q != '1)  stat_applied_d  = stat_applied_q + 32'd1;
        if (filt_inc && stat_filtered_q != '1)      stat_filtered_d = stat_filtered_q + 32'd1;
        if (miss_err_d && stat_miss_q != '1)        stat_miss_d     = stat_miss_q + 32'd1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stat_applied_q  <= '0;
            stat_filtered_q <= '0;
            stat_miss_q     <= '0;
        end else begin
            stat_applied_q  <= stat_applied_d;
            stat_filtered_q <= stat_filtered_d;
            stat_miss_q     <= stat_miss_d;
        end
    end

    assign stat_applied  = stat_applied_q;
    assign stat_filtered = stat_filtered_q;
    assign stat_miss     = stat_miss_q;
`endif

endmodule

// File: doc/mdp3_order_book.md
Name: mdp3_order_book

Overview:
- Consumes decoded MDP3 incremental-refresh entries from MDP3_Parser and maintains a price-sorted, depth-limited order book (bid and ask) for one security.
- Sits directly downstream of the parser. It drives enable_order_book back to the parser as the accept/halt handshake.
- Publishes registered top-of-book and level counts for downstream strategy and logging logic.

Parameters:
- DEPTH, 10, price levels kept per side (2..32).
- SEC_ID, 32'd0, SECURITY_ID this instance tracks; all other IDs are dropped.
- LVL_W, 5, width of level index/count; must satisfy 2^LVL_W > DEPTH.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- message_ready  in  1  parser entry valid.
- NUM_ORDERS  in  8  orders at level.
- QUANTITY  in  16  level quantity.
- PRICE  in  64  signed price mantissa.
- ACTION  in  2  0=new, 1=change, 2=delete, 3=clear side.
- ENTRY_TYPE  in  2  0=bid, 1=ask, 2/3=ignored.
- SECURITY_ID  in  32  instrument id.
- enable_order_book  out  1  high = block can accept an entry this cycle.
- best_bid_price  out  64  level 0 bid price, 0 when bid side empty.
- best_bid_qty  out  16  level 0 bid qty, 0 when empty.
- best_ask_price  out  64  level 0 ask price, 0 when empty.
- best_ask_qty  out  16  level 0 ask qty, 0 when empty.
- bid_count  out  LVL_W  valid bid levels.
- ask_count  out  LVL_W  valid ask levels.
- book_update  out  1  one-cycle pulse after any applied change.
- miss_err  out  1  one-cycle pulse when change/delete price is not found.

Behaviour:
- Reset (asynchronous):
  - All level storage and counts go to 0.
  - All outputs go to 0 except enable_order_book, which is 1.
  - State goes to IDLE.
  - Reset mid-operation aborts the entry; no pulse is emitted.
- Accept:
  - An entry is accepted when message_ready && enable_order_book.
  - All fields are captured in that cycle.
  - enable_order_book drops the following cycle and stays low until the state returns to IDLE.
  - message_ready while enable_order_book is low is ignored; the parser must hold.
- Filter:
  - If SECURITY_ID != SEC_ID or ENTRY_TYPE > 1, the entry is discarded in the accept cycle.
  - State stays IDLE; enable_order_book stays high; no pulse.
- State machine: IDLE -> SCAN -> APPLY -> IDLE. ACTION=3 goes IDLE -> APPLY directly.
- SCAN:
  - Index i starts at 0 and examines one level per cycle on the selected side.
  - new: stops at the first i where i==count or PRICE is better-or-equal vs level[i]. Bid "better" = greater (signed); ask "better" = less (signed).
  - change/delete: stops at the first i where i==count (not found) or PRICE==level[i].
  - SCAN takes exactly stop_i+1 cycles.
- APPLY (1 cycle):
  - new, equal price: overwrite qty and num_orders (acts as change).
  - new, i<DEPTH: levels i..DEPTH-2 shift down one, new level is written at i, count = min(count+1, DEPTH). The level at DEPTH-1 is lost when full.
  - new, i==DEPTH (book full and price worse than all levels): dropped, no update, no pulse.
  - change found: overwrite qty and num_orders at i.
  - delete found: levels i+1..count-1 shift up one, slot count-1 is zeroed, count-1.
  - change/delete not found: book unchanged; miss_err pulses.
  - clear: side storage and count go to 0.
- Outputs:
  - book_update pulses in the cycle after APPLY when the book changed.
  - Top-of-book and count outputs update in that same cycle.
  - enable_order_book returns high in that same cycle.
- Latency: accept-to-book_update = stop_i+3 cycles for scanned actions; 2 cycles for clear.
- quantity==0 on new/change is stored as-is; no implicit delete.

Optional Feature:
- Macro: BOOK_STATS_EN.
- Defined: adds three 32-bit saturating output counters:
  - stat_applied: book_update pulses.
  - stat_filtered: filtered or full-book-dropped entries.
  - stat_miss: miss_err pulses.
- All three counters reset to 0.
- Not defined: these ports and their counters are absent; all other behaviour is identical.

Test Plan:
- Bid inserts out of order: new bids at prices 100, 102, 101 (qty 5, 7, 6) -> levels 102, 101, 100; best_bid_price=102, best_bid_qty=7, bid_count=3. Each book_update arrives at stop_i+3 cycles after accept.
- Full-side insert, DEPTH=10: fill asks 200..209, then new ask at 199 -> best_ask_price=199, 209 dropped, ask_count=10. Then new ask at 250 -> no book_update, book unchanged.
- Delete and miss: delete bid 101 -> levels 102, 100, bid_count=2. Delete bid 150 -> miss_err pulse, no book_update.
- Change, filter, then clear:
  - Change bid at 102 to qty 9 -> best_bid_qty=9.
  - Entry with SECURITY_ID != SEC_ID -> enable_order_book never drops.
  - ACTION=3 on ask side -> ask_count=0, best_ask_price=0, book_update exactly 2 cycles after accept.
- Back-to-back and reset: hold message_ready high with 3 entries -> each accepted only while enable_order_book is high. Assert reset during SCAN -> counts=0, enable_order_book=1, no pulse.
- With BOOK_STATS_EN defined, after the above sequences -> stat_applied, stat_filtered and stat_miss equal the bench-counted totals.
